// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared definitions for the register-file write-back arbiter: default
// widths and the requester index constants used to address the two slots.
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int REG_DATA_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF      = 16;

   // Requester / slot indices
   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;

endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One-entry holding register for a pending register-file write.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (clears full only)
//   i_store       load i_addr/i_data and mark full at this edge
//   i_release     entry written this cycle; empties at this edge unless
//                 i_store refills it at the same edge
//   i_addr/i_data incoming destination register and data
//   o_full        slot holds a valid entry
//   o_addr/o_data held destination register and data
// -----------------------------------------------------------------------------
module wb_slot
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_WIDTH_DEF,
   parameter int DATA_W = REG_DATA_WIDTH_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_store,
   input  logic              i_release,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_full <= 1'b0;
      end else if (i_store) begin
         r_full <= 1'b1;
      end else if (i_release) begin
         r_full <= 1'b0;
      end
   end

   // Payload is qualified by r_full, so it needs no reset.
   always_ff @(posedge clk) begin
      if (i_store) begin
         r_addr <= i_addr;
         r_data <= i_data;
      end
   end

   assign o_full = r_full;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register-file write port (WE3/A3/WD3) between the ALU (req0)
// and load (req1) write-back paths. Each path owns a one-entry slot with a
// valid/ready handshake. Grants are round-robin; when both slots target the
// same register the older entry wins so writes retire in program order.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   stall                  suppresses grants, WE3 forced 0
//   reqN_valid/ready       requester handshake (N = 0 ALU, 1 load)
//   reqN_addr/data         destination register and write data
//   WE3/A3/WD3             register-file write port (A3/WD3 = 0 when idle)
//   pending                bit r set while a full slot targets register r
//   conflict_cnt           saturating count of cycles a full slot waited
//   clr_cnt                synchronous clear of conflict_cnt (wins over +1)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
   parameter int REG_COUNT      = 1 << REG_ADDR_WIDTH,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
   input  logic [REG_DATA_WIDTH-1:0] req0_data,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
   input  logic [REG_DATA_WIDTH-1:0] req1_data,
   output logic                      WE3,
   output logic [REG_ADDR_WIDTH-1:0] A3,
   output logic [REG_DATA_WIDTH-1:0] WD3,
   output logic [REG_COUNT-1:0]      pending,
   output logic [CNT_WIDTH-1:0]      conflict_cnt,
   input  logic                      clr_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]                w_valid;
   logic [1:0]                w_ready;
   logic [1:0]                w_xfer;
   logic [1:0]                w_store;
   logic [1:0]                w_full;
   logic [1:0]                w_grant;
   logic [1:0]                w_nfull;
   logic [1:0]                w_age_nxt;
   logic                      w_same_addr;
   logic                      w_wait;
   logic [REG_ADDR_WIDTH-1:0] w_in_addr [2];
   logic [REG_DATA_WIDTH-1:0] w_in_data [2];
   logic [REG_ADDR_WIDTH-1:0] w_addr    [2];
   logic [REG_DATA_WIDTH-1:0] w_data    [2];

   logic [1:0]                r_age;
   logic                      r_rr_ptr;
   logic [CNT_WIDTH-1:0]      r_cnt;

   assign w_valid[REQ_ALU]   = req0_valid;
   assign w_valid[REQ_LSU]   = req1_valid;
   assign w_in_addr[REQ_ALU] = req0_addr;
   assign w_in_addr[REQ_LSU] = req1_addr;
   assign w_in_data[REQ_ALU] = req0_data;
   assign w_in_data[REQ_LSU] = req1_data;

   // A slot being written this cycle can take a new entry at the same edge.
   assign w_ready    = {2{rst}} & (~w_full | w_grant);
   assign w_xfer     = w_valid & w_ready;
   assign req0_ready = w_ready[REQ_ALU];
   assign req1_ready = w_ready[REQ_LSU];

   // Writes to x0 complete the handshake but are never stored.
   always_comb begin
      w_store = '0;
      for (int i = 0; i < 2; i++) begin
         w_store[i] = w_xfer[i] && (w_in_addr[i] != '0);
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_slot
      wb_slot #(
         .ADDR_W (REG_ADDR_WIDTH),
         .DATA_W (REG_DATA_WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .i_store   (w_store[g]),
         .i_release (w_grant[g]),
         .i_addr    (w_in_addr[g]),
         .i_data    (w_in_data[g]),
         .o_full    (w_full[g]),
         .o_addr    (w_addr[g]),
         .o_data    (w_data[g])
      );
   end

   assign w_same_addr = (w_addr[REQ_ALU] == w_addr[REQ_LSU]);

   always_comb begin
      w_grant = 2'b00;
      if (!stall) begin
         case (w_full)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11: begin
               // Same destination: older entry first, keeps program order.
               if (w_same_addr) begin
                  w_grant = r_age[REQ_LSU] ? 2'b10 : 2'b01;
               end else begin
                  w_grant = r_rr_ptr ? 2'b10 : 2'b01;
               end
            end
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_nfull = w_store | (w_full & ~w_grant);
   assign w_wait  = |(w_full & ~w_grant);

   // Age: the entry that is alone, or that was there first, is the older one.
   // A simultaneous fill of both slots treats the load (slot1) as older,
   // which the store[0] branch covers since slot0 is then the newer entry.
   always_comb begin
      w_age_nxt = r_age;
      if (&w_nfull) begin
         if (w_store[REQ_ALU]) begin
            w_age_nxt = 2'b10;
         end else if (w_store[REQ_LSU]) begin
            w_age_nxt = 2'b01;
         end
      end else if (w_nfull[REQ_ALU]) begin
         w_age_nxt = 2'b01;
      end else if (w_nfull[REQ_LSU]) begin
         w_age_nxt = 2'b10;
      end else begin
         w_age_nxt = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_age    <= 2'b00;
         r_rr_ptr <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_age <= w_age_nxt;
         // Pointer only moves on a true round-robin decision.
         if (!stall && (&w_full) && !w_same_addr) begin
            r_rr_ptr <= ~r_rr_ptr;
         end
         if (clr_cnt) begin
            r_cnt <= '0;
         end else if (w_wait && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   assign conflict_cnt = r_cnt;

   always_comb begin
      WE3 = |w_grant;
      A3  = '0;
      WD3 = '0;
      if (w_grant[REQ_LSU]) begin
         A3  = w_addr[REQ_LSU];
         WD3 = w_data[REQ_LSU];
      end else if (w_grant[REQ_ALU]) begin
         A3  = w_addr[REQ_ALU];
         WD3 = w_data[REQ_ALU];
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < 2; i++) begin
         if (w_full[i]) begin
            pending[w_addr[i]] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int RC = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall = 1'b0;
   logic          req0_valid = 1'b0;
   logic          req0_ready;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_data = '0;
   logic          req1_valid = 1'b0;
   logic          req1_ready;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_data = '0;
   logic          WE3;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic [RC-1:0] pending;
   logic [CW-1:0] conflict_cnt;
   logic          clr_cnt = 1'b0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .REG_ADDR_WIDTH (AW),
      .REG_DATA_WIDTH (DW),
      .REG_COUNT      (RC),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_addr    (req0_addr),
      .req0_data    (req0_data),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_addr    (req1_addr),
      .req1_data    (req1_data),
      .WE3          (WE3),
      .A3           (A3),
      .WD3          (WD3),
      .pending      (pending),
      .conflict_cnt (conflict_cnt),
      .clr_cnt      (clr_cnt)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];

   // Handshake seen at the most recent rising edge
   logic hs0 = 1'b0;
   logic hs1 = 1'b0;
   always @(posedge clk) begin
      hs0 <= req0_valid && req0_ready;
      hs1 <= req1_valid && req1_ready;
   end

   // Monitor: every register-file write must match the next expected write
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst && WE3) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected: got A3=%0d WD3=%h, expected no write", A3, WD3);
         end else begin
            e = exp_q.pop_front();
            if (A3 !== e.a || WD3 !== e.d) begin
               failures++;
               $display("FAIL wr_order: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                        A3, WD3, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic send0(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req0_valid = 1'b1;
      req0_addr  = a;
      req0_data  = d;
      do begin
         tick();
         n++;
      end while (!hs0 && n < 50);
      if (!hs0) begin
         checks++;
         failures++;
         $display("FAIL send0_timeout: got no handshake, expected one within 50 cycles");
      end
      req0_valid = 1'b0;
   endtask

   task automatic send1(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      req1_valid = 1'b1;
      req1_addr  = a;
      req1_data  = d;
      do begin
         tick();
         n++;
      end while (!hs1 && n < 50);
      if (!hs1) begin
         checks++;
         failures++;
         $display("FAIL send1_timeout: got no handshake, expected one within 50 cycles");
      end
      req1_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   logic [CW-1:0] c0;

   initial begin
      // ---------------- reset ----------------
      rst        = 1'b0;
      req0_valid = 1'b1;
      req0_addr  = '0;
      req0_data  = 32'h55;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready0", 64'(req0_ready), 64'd0);
      chk("rst_ready1", 64'(req1_ready), 64'd0);
      chk("rst_we3", 64'(WE3), 64'd0);
      chk("rst_a3", 64'(A3), 64'd0);
      chk("rst_wd3", 64'(WD3), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);
      @(negedge clk) rst = 1'b1;
      tick();
      chk("rel_ready0", 64'(req0_ready), 64'd1);
      chk("rel_ready1", 64'(req1_ready), 64'd1);
      chk("rel_x0_hs", 64'(hs0), 64'd1);
      req0_valid = 1'b0;
      tick();

      // ---------------- single write ----------------
      push(5, 32'hDEADBEEF);
      send0(5, 32'hDEADBEEF);
      chk("sw_we3", 64'(WE3), 64'd1);
      chk("sw_a3", 64'(A3), 64'd5);
      chk("sw_pending", 64'(pending), 64'h20);
      tick();
      chk("sw_pending_clr", 64'(pending), 64'd0);
      chk("sw_we3_idle", 64'(WE3), 64'd0);
      drain("sw_drain");

      // ---------------- same address, load first ----------------
      stall = 1'b1;
      push(7, 32'd1);
      push(7, 32'd2);
      send1(7, 32'd1);
      send0(7, 32'd2);
      chk("sa_pending", 64'(pending), 64'h80);
      chk("sa_ready0_full", 64'(req0_ready), 64'd0);
      chk("sa_ready1_full", 64'(req1_ready), 64'd0);
      stall = 1'b0;
      drain("sa_drain");

      // ---------------- same address, simultaneous fill ----------------
      stall = 1'b1;
      push(7, 32'd1);
      push(7, 32'd2);
      fork
         send0(7, 32'd2);
         send1(7, 32'd1);
      join
      stall = 1'b0;
      drain("sim_drain");

      // ---------------- round-robin ----------------
      c0 = conflict_cnt;
      for (int i = 0; i < 3; i++) begin
         push(3, 32'h30 + i);
         push(4, 32'h40 + i);
      end
      fork
         begin
            for (int i = 0; i < 3; i++) send0(3, 32'h30 + i);
         end
         begin
            for (int j = 0; j < 3; j++) send1(4, 32'h40 + j);
         end
      join
      drain("rr_drain");
      chk("rr_cnt", 64'(conflict_cnt), 64'(c0 + 16'd5));

      // ---------------- x0 filter ----------------
      send0(0, 32'h99);
      chk("x0_pending", 64'(pending), 64'd0);
      chk("x0_we3", 64'(WE3), 64'd0);
      tick();
      chk("x0_we3_next", 64'(WE3), 64'd0);

      // ---------------- stall ----------------
      stall = 1'b1;
      push(9, 32'hABC);
      send0(9, 32'hABC);
      c0 = conflict_cnt;
      chk("st_pending", 64'(pending), 64'h200);
      chk("st_ready0", 64'(req0_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_we3", 64'(WE3), 64'd0);
      end
      chk("st_cnt", 64'(conflict_cnt), 64'(c0 + 16'd3));
      stall = 1'b0;
      #1;
      chk("st_release_we3", 64'(WE3), 64'd1);
      chk("st_release_a3", 64'(A3), 64'd9);
      drain("st_drain");

      // ---------------- counter saturation and clear ----------------
      stall = 1'b1;
      push(10, 32'h1010);
      send0(10, 32'h1010);
      clr_cnt = 1'b1;
      tick();
      chk("cnt_clr_pre", 64'(conflict_cnt), 64'd0);
      clr_cnt = 1'b0;
      repeat (65535) tick();
      chk("cnt_full", 64'(conflict_cnt), 64'hFFFF);
      repeat (3) tick();
      chk("cnt_sat", 64'(conflict_cnt), 64'hFFFF);
      clr_cnt = 1'b1;
      tick();
      chk("cnt_clr_prio", 64'(conflict_cnt), 64'd0);
      clr_cnt = 1'b0;
      stall = 1'b0;
      drain("cnt_drain");

      // ---------------- reset mid-operation ----------------
      stall = 1'b1;
      send0(12, 32'hC);
      chk("mr_pending_set", 64'(pending), 64'h1000);
      rst = 1'b0;
      #1;
      chk("mr_pending_rst", 64'(pending), 64'd0);
      chk("mr_ready0_rst", 64'(req0_ready), 64'd0);
      tick();
      tick();
      @(negedge clk) rst = 1'b1;
      stall = 1'b0;
      repeat (3) tick();
      chk("mr_pending_after", 64'(pending), 64'd0);
      chk("mr_cnt_after", 64'(conflict_cnt), 64'd0);
      chk("mr_queue", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) between two write-back requesters: req0 (ALU result path) and req1 (load/memory result path).
Each requester gets a one-entry holding slot with a valid/ready handshake. Grants use round-robin, with an age override so that writes to the same register retire in order. The block also exports a per-register pending mask for the hazard unit and a saturating conflict counter.

Parameters:
REG_ADDR_WIDTH, 5, register index width
REG_DATA_WIDTH, 32, register data width
REG_COUNT, 1<<REG_ADDR_WIDTH, number of architectural registers
CNT_WIDTH, 16, width of conflict counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
stall  in  1  pipeline stall; suppresses grants, WE3 forced 0
req0_valid  in  1  ALU write request
req0_ready  out  1  slot0 can accept
req0_addr  in  REG_ADDR_WIDTH  destination register
req0_data  in  REG_DATA_WIDTH  write data
req1_valid  in  1  load write request
req1_ready  out  1  slot1 can accept
req1_addr  in  REG_ADDR_WIDTH  destination register
req1_data  in  REG_DATA_WIDTH  write data
WE3  out  1  regfile write enable
A3  out  REG_ADDR_WIDTH  regfile write address
WD3  out  REG_DATA_WIDTH  regfile write data
pending  out  REG_COUNT  bit r = 1 while any full slot targets register r
conflict_cnt  out  CNT_WIDTH  saturating count of cycles in which a full slot waited
clr_cnt  in  1  synchronous clear of conflict_cnt

Behaviour:
- State: slotN_full, slotN_addr, slotN_data, slotN_age (1 bit, set when the slot is older than the other full slot), rr_ptr (1 bit), conflict_cnt.
- Reset (rst=0, async):
  - all slots empty, rr_ptr=0, conflict_cnt=0.
  - WE3=0, A3=0, WD3=0, pending=0.
  - reqN_ready=0 while rst=0, 1 from the first cycle after release.
- Handshake:
  - reqN_ready = !slotN_full || grantN. A slot granted this cycle accepts a new entry at the same edge.
  - Transfer occurs on valid && ready at a rising edge. valid must hold, with stable addr/data, until ready.
- x0 filter: a transfer with addr==0 is consumed (ready behaves normally) but not stored. No WE3 results.
- Grant (combinational, evaluated only when stall=0):
  - only one slot full -> grant it.
  - both full, addr differ -> grant slot[rr_ptr]; rr_ptr toggles at the edge.
  - both full, addr equal -> grant the slot with age=1; rr_ptr unchanged.
  - both filled at the same edge -> slot1 counts as older (load precedes ALU in program order).
- Write port:
  - WE3 = any grant; A3/WD3 come from the granted slot.
  - When WE3=0, A3 and WD3 are driven 0.
  - Latency: data accepted at edge k appears on WE3/A3/WD3 in the cycle after edge k at the earliest. The granted slot empties at the next edge.
- stall=1:
  - no grant, WE3=0, slots hold, rr_ptr holds.
  - ready still reflects slot emptiness, so empty slots may still fill.
- Age update:
  - filling a slot while the other is full -> the filling slot gets age=0 and the other age=1.
  - emptying a slot -> the remaining slot gets age=1.
- pending: OR of one-hot decodes of full slot addresses. It clears in the cycle after the write edge.
- conflict_cnt:
  - +1 on each cycle where a full slot is not granted (stall or lost arbitration); +1 max per cycle.
  - saturates at all-ones.
  - clr_cnt has priority over increment.
- Reset mid-operation: pending slot contents are discarded and no write is issued.

Decomposition:
- Shared package: REG_ADDR_WIDTH/REG_DATA_WIDTH defaults, REG_COUNT, requester index constants (REQ_ALU=0, REQ_LSU=1).
- One natural sub-module: wb_slot (single holding register with full/addr/data and accept/release), instantiated twice. Arbitration, age and counter logic stay in the top.

Test Plan:
- Reset: hold rst=0 with req0_valid=1 -> req0_ready=0, WE3=0, pending=0. Release -> ready=1 the next cycle.
- Single write: req0 addr=5, data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF, pending[5]=1. The cycle after that, pending=0.
- Round-robin: hold req0 (addr 3) and req1 (addr 4) continuously -> WE3 alternates A3=3,4,3,4 starting with 3; conflict_cnt increments 1 per cycle.
- Same-address ordering: req1 addr=7 data=1 accepted first, then req0 addr=7 data=2 -> writes occur in order 1 then 2 regardless of rr_ptr. The same test with a simultaneous fill also gives 1 then 2.
- x0 and stall:
  - req0 addr=0 -> accepted, no WE3, pending unchanged.
  - stall=1 for 3 cycles with slot full -> WE3=0 throughout, conflict_cnt +3; the write issues in the first cycle after stall drops.
- Counter: force saturation, drive 0xFFFF plus one conflict -> stays 0xFFFF. clr_cnt with a concurrent conflict -> 0.
